// File: rtl/mips_pkg.sv
// Shared MIPS definitions: access-size encodings, LSU state encoding and
// alignment helpers used by the load/store unit.
package mips_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11   // reserved, behaves as a word access
    } lsu_size_e;

    typedef enum logic {
        LSU_IDLE   = 1'b0,
        LSU_RMW_WR = 1'b1
    } lsu_state_e;

    // Sub-word stores need a read-modify-write; everything else is a full word.
    function automatic logic is_subword(input lsu_size_e size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

    // Half needs an even address, word (and reserved) needs a 4-byte aligned one.
    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Big-endian lane logic: byte offset 0 is bits [31:24], half offset 0 is [31:16].
// Extracts and sign/zero-extends a load lane, and inserts store data into a word.
module lsu_lane_merge
    import mips_pkg::*;
(
    input  logic [31:0] word_i,        // memory word being read or merged into
    input  logic [1:0]  offset_i,      // byte offset within the word
    input  lsu_size_e   size_i,
    input  logic        zext_i,        // zero-extend sub-word loads
    input  logic [31:0] store_data_i,  // sub-word store data sits in the low bits
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [4:0]  byte_lsb;  // (3 - offset) * 8
    logic [4:0]  half_lsb;  // (1 - offset[1]) * 16

    assign byte_lsb  = {~offset_i, 3'b000};
    assign half_lsb  = {~offset_i[1], 4'b0000};
    assign byte_lane = word_i[byte_lsb +: 8];
    assign half_lane = word_i[half_lsb +: 16];

    // Select the load lane / splice the store lane according to access size.
    always_comb begin
        // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latch).
        load_data_o = word_i;
        merged_o    = store_data_i;
        case (size_i)
            SZ_BYTE: begin
                load_data_o = zext_i ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
                merged_o    = word_i;
                merged_o[byte_lsb +: 8] = store_data_i[7:0];
            end
            SZ_HALF: begin
                load_data_o = zext_i ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
                merged_o    = word_i;
                merged_o[half_lsb +: 16] = store_data_i[15:0];
            end
            default: begin
                load_data_o = word_i;
                merged_o    = store_data_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit in front of a word-addressed data memory.
// Loads and word stores complete in one cycle; sb/sh take two cycles
// (read the word, then write the merged word) because memory cannot
// read and write in the same cycle.
// Optional feature: define MISALIGN_TRAP_EN to flag and suppress misaligned
// half/word accesses; otherwise the offending low address bits are ignored.
module load_store_unit
    import mips_pkg::*;
#(
    parameter int WORD_SIZE    = 32,  // only 32 is supported
    parameter int ADDRESS_SIZE = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             lsu_addr,
    input  logic [WORD_SIZE-1:0]    lsu_wdata,
    input  logic                    lsu_read,
    input  logic                    lsu_write,
    input  logic [1:0]              lsu_size,
    input  logic                    lsu_unsigned,
    output logic [WORD_SIZE-1:0]    lsu_rdata,
    output logic                    lsu_stall,
    output logic                    lsu_misalign,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]    mem_wdata,
    output logic                    mem_read,
    output logic                    mem_write,
    input  logic [WORD_SIZE-1:0]    mem_rdata
);

    lsu_state_e             state_q, state_d;
    logic [31:0]            addr_q;
    logic [WORD_SIZE-1:0]   word_q;
    logic [WORD_SIZE-1:0]   wdata_q;
    lsu_size_e              size_q;
    logic                   latch_en;

    lsu_size_e              req_size;
    logic                   misalign;
    logic                   in_rmw;
    logic [WORD_SIZE-1:0]   load_data;
    logic [WORD_SIZE-1:0]   merged;

    assign req_size = lsu_size_e'(lsu_size);
    assign in_rmw   = (state_q == LSU_RMW_WR);

    // One lane unit serves both phases: live request in IDLE, latched store in RMW_WR.
    lsu_lane_merge u_lane_merge (
        .word_i       (in_rmw ? word_q       : mem_rdata),
        .offset_i     (in_rmw ? addr_q[1:0]  : lsu_addr[1:0]),
        .size_i       (in_rmw ? size_q       : req_size),
        .zext_i       (lsu_unsigned),
        .store_data_i (in_rmw ? wdata_q      : lsu_wdata),
        .load_data_o  (load_data),
        .merged_o     (merged)
    );

`ifdef MISALIGN_TRAP_EN
    assign misalign = !rst && !in_rmw && (lsu_read || lsu_write)
                    && is_misaligned(req_size, lsu_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif
    assign lsu_misalign = misalign;

    // Next-state and memory/pipeline strobes; everything is held at 0 during reset.
    always_comb begin
        state_d   = state_q;
        latch_en  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        mem_addr  = ADDRESS_SIZE'(lsu_addr[31:2]);
        lsu_rdata = '0;
        lsu_stall = 1'b0;
        if (!rst) begin
            case (state_q)
                LSU_IDLE: begin
                    if (misalign) begin
                        // access suppressed, only the flag is raised
                    end else if (lsu_read) begin
                        // a simultaneous write is illegal and simply dropped
                        mem_read  = 1'b1;
                        lsu_rdata = load_data;
                    end else if (lsu_write) begin
                        if (is_subword(req_size)) begin
                            mem_read  = 1'b1;
                            lsu_stall = 1'b1;
                            latch_en  = 1'b1;
                            state_d   = LSU_RMW_WR;
                        end else begin
                            mem_write = 1'b1;
                            mem_wdata = lsu_wdata;
                        end
                    end
                end
                LSU_RMW_WR: begin
                    mem_write = 1'b1;
                    mem_addr  = ADDRESS_SIZE'(addr_q[31:2]);
                    mem_wdata = merged;
                    state_d   = LSU_IDLE;
                end
                default: state_d = LSU_IDLE;
            endcase
        end
    end

    // State register plus the read-phase capture of the sub-word store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the capture registers are reset too, so a reset mid-RMW leaves nothing stale behind.
            state_q <= LSU_IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            size_q  <= SZ_BYTE;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            if (latch_en) begin
                addr_q  <= lsu_addr;
                word_q  <= mem_rdata;
                wdata_q <= lsu_wdata;
                size_q  <= req_size;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed literal cases followed by
// randomized traffic compared every cycle against a behavioural model.
// Honours MISALIGN_TRAP_EN when defined for the build.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic        lsu_read = 1'b0;
    logic        lsu_write = 1'b0;
    logic [1:0]  lsu_size = 2'b00;
    logic        lsu_unsigned = 1'b0;
    logic [31:0] lsu_rdata;
    logic        lsu_stall;
    logic        lsu_misalign;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.WORD_SIZE(32), .ADDRESS_SIZE(32)) dut (
        .clk(clk), .rst(rst),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_read(lsu_read), .lsu_write(lsu_write),
        .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned),
        .lsu_rdata(lsu_rdata), .lsu_stall(lsu_stall), .lsu_misalign(lsu_misalign),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    // Data memory seen by the DUT (128 words, byte addresses 0..511)
    logic [31:0] tb_mem    [128];
    // Model's idea of what memory should hold
    logic [31:0] model_mem [128];

    assign mem_rdata = tb_mem[mem_addr[6:0]];

    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_addr[6:0]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return a[0];
        return a[1:0] != 2'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] sz, input logic uns);
        int unsigned v;
        int unsigned shift;
        if (sz == 2'd0) begin
            shift = 8 * (3 - int'(a[1:0]));
            v = (w >> shift) & 32'hFF;
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            shift = a[1] ? 0 : 16;
            v = (w >> shift) & 32'hFFFF;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] a,
                                                input logic [1:0] sz, input logic [31:0] d);
        int unsigned shift;
        int unsigned mask;
        if (sz == 2'd0) begin
            shift = 8 * (3 - int'(a[1:0]));
            mask  = 32'hFF;
        end else if (sz == 2'd1) begin
            shift = a[1] ? 0 : 16;
            mask  = 32'hFFFF;
        end else begin
            return d;
        end
        return (w & ~(mask << shift)) | ((d & mask) << shift);
    endfunction

    bit          pend = 1'b0;
    logic [31:0] pend_addr, pend_word, pend_data;
    logic [1:0]  pend_size;

    // Model state update at each clock edge (reset cancels any pending store)
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend = 1'b0;
        end else if (pend) begin
            model_mem[pend_addr[8:2]] = model_store(pend_word, pend_addr, pend_size, pend_data);
            pend = 1'b0;
        end else if ((lsu_read || lsu_write) && model_misaligned(lsu_size, lsu_addr)) begin
            // suppressed access
        end else if (lsu_read) begin
            // loads do not change memory
        end else if (lsu_write) begin
            if (lsu_size >= 2'd2) begin
                model_mem[lsu_addr[8:2]] = lsu_wdata;
            end else begin
                pend      = 1'b1;
                pend_addr = lsu_addr;
                pend_word = model_mem[lsu_addr[8:2]];
                pend_size = lsu_size;
                pend_data = lsu_wdata;
            end
        end
    end

    // Compare DUT outputs against the model every cycle, mid-cycle
    always @(negedge clk) begin
        logic [31:0] e_rdata, e_wdata, e_addr;
        logic        e_rd, e_wr, e_stall, e_mis;
        e_rdata = '0; e_wdata = '0; e_rd = 1'b0; e_wr = 1'b0; e_stall = 1'b0; e_mis = 1'b0;
        e_addr  = lsu_addr >> 2;
        if (!rst) begin
            if (pend) begin
                e_wr    = 1'b1;
                e_addr  = pend_addr >> 2;
                e_wdata = model_store(pend_word, pend_addr, pend_size, pend_data);
            end else if ((lsu_read || lsu_write) && model_misaligned(lsu_size, lsu_addr)) begin
                e_mis = 1'b1;
            end else if (lsu_read) begin
                e_rd    = 1'b1;
                e_rdata = model_load(model_mem[lsu_addr[8:2]], lsu_addr, lsu_size, lsu_unsigned);
            end else if (lsu_write) begin
                if (lsu_size >= 2'd2) begin
                    e_wr    = 1'b1;
                    e_wdata = lsu_wdata;
                end else begin
                    e_rd    = 1'b1;
                    e_stall = 1'b1;
                end
            end
        end
        check("mem_read",     32'(mem_read),     32'(e_rd));
        check("mem_write",    32'(mem_write),    32'(e_wr));
        check("lsu_stall",    32'(lsu_stall),    32'(e_stall));
        check("lsu_misalign", 32'(lsu_misalign), 32'(e_mis));
        check("lsu_rdata",    lsu_rdata,         e_rdata);
        check("mem_wdata",    mem_wdata,         e_wdata);
        if (e_rd || e_wr) check("mem_addr", mem_addr, e_addr);
        check("strobe_excl",  32'(mem_read & mem_write), 32'd0);
    end

    // ---------------- stimulus ----------------
    task automatic req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
        lsu_read = rd; lsu_write = wr; lsu_size = sz; lsu_unsigned = uns;
        lsu_addr = a; lsu_wdata = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            logic [31:0] v;
            v = $urandom;
            tb_mem[i]    = v;
            model_mem[i] = v;
        end

        // Reset state: all outputs zero
        req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("rst_rdata",    lsu_rdata, 32'h0);
        check("rst_stall",    32'(lsu_stall), 32'h0);
        check("rst_misalign", 32'(lsu_misalign), 32'h0);
        check("rst_strobes",  32'({mem_read, mem_write}), 32'h0);
        check("rst_wdata",    mem_wdata, 32'h0);
        next_cycle();
        rst = 1'b0;

        // 1: sw then lw
        req(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678);
        @(negedge clk);
        check("t1_sw_write", 32'(mem_write), 32'h1);
        check("t1_sw_addr",  mem_addr, 32'h40);
        check("t1_sw_stall", 32'(lsu_stall), 32'h0);
        next_cycle();
        req(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        check("t1_lw", lsu_rdata, 32'h12345678);
        next_cycle();

        // 2: sb 0xAB @0x101
        req(1'b0, 1'b1, 2'd0, 1'b0, 32'h101, 32'h000000AB);
        @(negedge clk);
        check("t2_c1_read",  32'(mem_read), 32'h1);
        check("t2_c1_stall", 32'(lsu_stall), 32'h1);
        next_cycle();
        @(negedge clk);
        check("t2_c2_write", 32'(mem_write), 32'h1);
        check("t2_c2_wdata", mem_wdata, 32'h12AB5678);
        check("t2_c2_stall", 32'(lsu_stall), 32'h0);
        next_cycle();

        // 3: sub-word loads and sh
        req(1'b1, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
        @(negedge clk); check("t3_lb",  lsu_rdata, 32'hFFFFFFAB); next_cycle();
        req(1'b1, 1'b0, 2'd0, 1'b1, 32'h101, 32'h0);
        @(negedge clk); check("t3_lbu", lsu_rdata, 32'h000000AB); next_cycle();
        req(1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
        @(negedge clk); check("t3_lh",  lsu_rdata, 32'h00005678); next_cycle();
        req(1'b0, 1'b1, 2'd1, 1'b0, 32'h100, 32'h00009999);
        next_cycle();
        @(negedge clk); check("t3_sh_wdata", mem_wdata, 32'h99995678); next_cycle();
        req(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        @(negedge clk); check("t3_lw", lsu_rdata, 32'h99995678); next_cycle();

        // 4: reset during RMW write phase
        req(1'b0, 1'b1, 2'd0, 1'b0, 32'h100, 32'h00000000);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("t4_no_write", 32'(mem_write), 32'h0);
        check("t4_stall",    32'(lsu_stall), 32'h0);
        next_cycle();
        rst = 1'b0;
        req(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        @(negedge clk); check("t4_lw", lsu_rdata, 32'h99995678); next_cycle();

        // 5: lh @0x103
        req(1'b1, 1'b0, 2'd1, 1'b0, 32'h103, 32'h0);
        @(negedge clk);
`ifdef MISALIGN_TRAP_EN
        check("t5_misalign", 32'(lsu_misalign), 32'h1);
        check("t5_no_read",  32'(mem_read), 32'h0);
        check("t5_rdata",    lsu_rdata, 32'h0);
`else
        check("t5_misalign", 32'(lsu_misalign), 32'h0);
        check("t5_rdata",    lsu_rdata, 32'h00005678);
`endif
        next_cycle();

        // 6: read and write together -> load wins, write dropped
        req(1'b1, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        check("t6_read",  32'(mem_read), 32'h1);
        check("t6_write", 32'(mem_write), 32'h0);
        next_cycle();
        req(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        @(negedge clk); check("t6_lw", lsu_rdata, 32'h99995678); next_cycle();

        // Randomized traffic, with occasional asynchronous reset pulses
        for (int i = 0; i < 3000; i++) begin
            req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 32'($urandom_range(0, 511)), $urandom);
            rst = ($urandom_range(0, 99) == 0);
            next_cycle();
        end
        rst = 1'b0;
        req(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
